// File: rtl/mul_seq_ctrl.sv
// Arbiter and pin sequencer for the 4x4 shift-add nibble multiplier.
// Optional macro MUL_SEQ_ROUND_ROBIN_EN: round-robin tie-break (default: fixed priority to A).
module mul_seq_ctrl #(
    parameter int STEPS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic [3:0] XA,
    input  logic [3:0] YA,
    input  logic [3:0] XB,
    input  logic [3:0] YB,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       ACK_A,
    output logic       ACK_B,
    output logic [7:0] P,
    output logic       BUSY,
    output logic [3:0] MUL_DIN,
    output logic       MUL_LOAD,
    output logic       MUL_RSEL,
    output logic       MUL_CLK,
    input  logic [3:0] MUL_R
);
    localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDM  = 3'd1,
        S_LDA  = 3'd2,
        S_RUN  = 3'd3,
        S_RDHI = 3'd4,
        S_RDLO = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_step;
    logic [2:0] w_step_nxt;
    logic       r_half;
    logic       w_half_nxt;
    logic       w_start;
    logic       w_win_b;
    logic       w_grant_b;
    logic [3:0] w_y_sel;
    logic       r_win_b;
    logic [3:0] r_x;
    logic [3:0] r_p_hi;
    logic [7:0] r_p;
    logic       r_gnt_a;
    logic       r_gnt_b;
    logic       r_ack_a;
    logic       r_ack_b;
    logic       r_busy;
    logic [3:0] r_mul_din;
    logic       r_mul_load;
    logic       r_mul_rsel;
    logic       r_mul_clk;

`ifdef MUL_SEQ_ROUND_ROBIN_EN
    logic r_prio_b;

    assign w_win_b = REQ_B && (!REQ_A || r_prio_b);

    // Tie-break pointer: favour whoever was not served, updated as each operation completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prio_b <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_prio_b <= !r_win_b;
        end else begin
            r_prio_b <= r_prio_b;
        end
    end
`else
    assign w_win_b = REQ_B && !REQ_A;
`endif

    // The winner is only decided in IDLE; afterwards the latched choice holds.
    assign w_grant_b = w_start ? w_win_b : r_win_b;
    assign w_y_sel   = w_win_b ? YB : YA;

    // Next-state logic; r_half marks the high half of a MUL_CLK pulse in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_half_nxt  = r_half;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ_A || REQ_B) begin
                    w_state_nxt = S_LDM;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LDM: w_state_nxt = S_LDA;
            S_LDA: begin
                w_state_nxt = S_RUN;
                w_step_nxt  = 3'd0;
                w_half_nxt  = 1'b1;
            end
            S_RUN: begin
                if (r_half) begin
                    w_half_nxt = 1'b0;
                end else if (r_step == STEP_LAST) begin
                    w_state_nxt = S_RDHI;
                end else begin
                    w_step_nxt = r_step + 3'd1;
                    w_half_nxt = 1'b1;
                end
            end
            S_RDHI:  w_state_nxt = S_RDLO;
            S_RDLO:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, step counter and latched request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_step  <= 3'd0;
            r_half  <= 1'b0;
            r_win_b <= 1'b0;
            r_x     <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_half  <= w_half_nxt;
            if (w_start) begin
                r_win_b <= w_win_b;
                r_x     <= w_win_b ? XB : XA;
            end else begin
                r_win_b <= r_win_b;
                r_x     <= r_x;
            end
        end
    end

    // Outputs are registered from the next state so each one lines up with its state.
    // Y goes straight into the LDM pin register, which is its latch point.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_busy     <= 1'b0;
            r_mul_din  <= 4'h0;
            r_mul_load <= 1'b0;
            r_mul_rsel <= 1'b0;
            r_mul_clk  <= 1'b0;
        end else begin
            r_busy     <= (w_state_nxt != S_IDLE);
            r_gnt_a    <= (w_state_nxt != S_IDLE) && !w_grant_b;
            r_gnt_b    <= (w_state_nxt != S_IDLE) && w_grant_b;
            r_ack_a    <= (w_state_nxt == S_DONE) && !w_grant_b;
            r_ack_b    <= (w_state_nxt == S_DONE) && w_grant_b;
            r_mul_load <= (w_state_nxt == S_LDM) || (w_state_nxt == S_LDA);
            r_mul_rsel <= (w_state_nxt == S_LDA) || (w_state_nxt == S_RDLO);
            r_mul_clk  <= (w_state_nxt == S_RUN) && w_half_nxt;
            case (w_state_nxt)
                S_LDM:   r_mul_din <= w_y_sel;
                S_LDA:   r_mul_din <= r_x;
                default: r_mul_din <= 4'h0;
            endcase
        end
    end

    // Product readback: high nibble in RDHI, full product presented on entry to DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p_hi <= 4'h0;
            r_p    <= 8'h00;
        end else begin
            if (r_state == S_RDHI) begin
                r_p_hi <= MUL_R;
            end else begin
                r_p_hi <= r_p_hi;
            end
            if (r_state == S_RDLO) begin
                r_p <= {r_p_hi, MUL_R};
            end else begin
                r_p <= r_p;
            end
        end
    end

    assign GNT_A    = r_gnt_a;
    assign GNT_B    = r_gnt_b;
    assign ACK_A    = r_ack_a;
    assign ACK_B    = r_ack_b;
    assign P        = r_p;
    assign BUSY     = r_busy;
    assign MUL_DIN  = r_mul_din;
    assign MUL_LOAD = r_mul_load;
    assign MUL_RSEL = r_mul_rsel;
    assign MUL_CLK  = r_mul_clk;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a behavioural nibble-multiplier model
// and a request-level reference model of arbitration, latency and products.
module tb_mul_seq_ctrl;
    localparam int STEPS = 4;
    localparam int LAT   = 5 + 2 * STEPS;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       REQ_A = 1'b0;
    logic       REQ_B = 1'b0;
    logic [3:0] XA = 4'h0;
    logic [3:0] YA = 4'h0;
    logic [3:0] XB = 4'h0;
    logic [3:0] YB = 4'h0;
    logic       GNT_A, GNT_B, ACK_A, ACK_B, BUSY;
    logic [7:0] P;
    logic [3:0] MUL_DIN;
    logic       MUL_LOAD, MUL_RSEL, MUL_CLK;
    logic [3:0] MUL_R;

    int n_checks = 0;
    int n_pass   = 0;

    int st_pulses, st_adj, st_din, st_gnt_a, st_gnt_b;
    bit ref_last_b = 1'b1;

    mul_seq_ctrl #(.STEPS(STEPS)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .XA(XA), .YA(YA), .XB(XB), .YB(YB),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .ACK_A(ACK_A), .ACK_B(ACK_B),
        .P(P), .BUSY(BUSY),
        .MUL_DIN(MUL_DIN), .MUL_LOAD(MUL_LOAD), .MUL_RSEL(MUL_RSEL), .MUL_CLK(MUL_CLK),
        .MUL_R(MUL_R)
    );

    initial forever #5 CLK = ~CLK;

    // Multiplier model: product is only correct after exactly STEPS step pulses.
    logic [3:0] m_x = 4'h0;
    logic [3:0] m_y = 4'h0;
    int         m_cnt = 0;
    logic       m_prev = 1'b0;
    logic [7:0] m_prod;
    logic [3:0] m_nib;

    always @(posedge CLK) begin
        if (MUL_LOAD && !MUL_RSEL) begin
            m_y   <= MUL_DIN;
            m_cnt <= 0;
        end else if (MUL_LOAD && MUL_RSEL) begin
            m_x <= MUL_DIN;
        end else if (MUL_CLK && !m_prev) begin
            m_cnt <= m_cnt + 1;
        end
        m_prev <= MUL_CLK;
    end

    assign m_prod = {4'h0, m_x} * {4'h0, m_y};
    assign m_nib  = MUL_RSEL ? m_prod[3:0] : m_prod[7:4];
    assign MUL_R  = (m_cnt == STEPS) ? m_nib : ~m_nib;

    function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        return 8'(int'(x) * int'(y));
    endfunction

    // Reference arbitration: a lone requester wins; ties go to A, or under
    // round-robin to whichever requester was not served most recently.
    function automatic bit ref_pick_b(input bit a, input bit b);
        if (a && b) begin
`ifdef MUL_SEQ_ROUND_ROBIN_EN
            return !ref_last_b;
`else
            return 1'b0;
`endif
        end
        return b;
    endfunction

    task automatic settle();
        @(posedge CLK); #1;
    endtask

    task automatic issue(input bit b, input logic [3:0] x, input logic [3:0] y);
        if (b) begin XB = x; YB = y; REQ_B = 1'b1; end
        else   begin XA = x; YA = y; REQ_A = 1'b1; end
    endtask

    task automatic wait_ack(input bit drop, output int cyc, output logic [7:0] p, output bit got_b);
        bit prev_clk;
        prev_clk = 1'b0;
        cyc = -1; p = 8'h00; got_b = 1'b0;
        st_pulses = 0; st_adj = 0; st_din = 0; st_gnt_a = 0; st_gnt_b = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK); #1;
            if (MUL_CLK) begin
                st_pulses++;
                if (prev_clk) st_adj++;
            end
            prev_clk = MUL_CLK;
            if (!MUL_LOAD && MUL_DIN != 4'h0) st_din++;
            if (GNT_A) st_gnt_a++;
            if (GNT_B) st_gnt_b++;
            if (ACK_A || ACK_B) begin
                cyc = k; p = P; got_b = ACK_B;
                if (drop) begin
                    if (ACK_B) REQ_B = 1'b0;
                    else       REQ_A = 1'b0;
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) settle();
        n_checks++;
        if ({GNT_A, GNT_B, ACK_A, ACK_B, BUSY} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {GNT_A, GNT_B, ACK_A, ACK_B, BUSY});
        else n_pass++;
        n_checks++;
        if ({MUL_DIN, MUL_LOAD, MUL_RSEL, MUL_CLK, P} !== 15'b0)
            $display("FAIL reset_data: got din=%h load=%b rsel=%b clk=%b p=%h want all 0",
                     MUL_DIN, MUL_LOAD, MUL_RSEL, MUL_CLK, P);
        else n_pass++;
        RST = 1'b0;
        ref_last_b = 1'b1;
        settle();
    endtask

    task automatic test_basic();
        int cyc; logic [7:0] p; bit gb;
        issue(1'b0, 4'd7, 4'd9);
        wait_ack(1'b1, cyc, p, gb);
        ref_last_b = 1'b0;
        n_checks++;
        if (cyc !== LAT) $display("FAIL basic_latency: got %0d want %0d", cyc, LAT); else n_pass++;
        n_checks++;
        if (p !== 8'h3F || gb !== 1'b0) $display("FAIL basic_product: got p=%h ackb=%b want 3f/0", p, gb); else n_pass++;
        n_checks++;
        if (st_pulses !== STEPS || st_adj !== 0) $display("FAIL basic_pulses: got %0d adj=%0d want %0d adj=0", st_pulses, st_adj, STEPS); else n_pass++;
        n_checks++;
        if (st_gnt_a !== LAT || st_gnt_b !== 0) $display("FAIL basic_gnt: got a=%0d b=%0d want %0d/0", st_gnt_a, st_gnt_b, LAT); else n_pass++;
        n_checks++;
        if (st_din !== 0) $display("FAIL basic_din_idle: got %0d stray cycles want 0", st_din); else n_pass++;
        settle();
        n_checks++;
        if (P !== 8'h3F || ACK_A !== 1'b0 || BUSY !== 1'b0 || GNT_A !== 1'b0)
            $display("FAIL basic_hold: got p=%h ack=%b busy=%b gnt=%b want 3f/0/0/0", P, ACK_A, BUSY, GNT_A);
        else n_pass++;
    endtask

    task automatic test_corners();
        logic [3:0] xs [3] = '{4'd15, 4'd0, 4'd1};
        logic [3:0] ys [3] = '{4'd15, 4'd11, 4'd1};
        int cyc; logic [7:0] p; bit gb;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, xs[i], ys[i]);
            wait_ack(1'b1, cyc, p, gb);
            ref_last_b = 1'b0;
            n_checks++;
            if (p !== ref_mul(xs[i], ys[i]) || cyc !== LAT)
                $display("FAIL corner_%0d: got p=%h cyc=%0d want %h/%0d", i, p, cyc, ref_mul(xs[i], ys[i]), LAT);
            else n_pass++;
            settle();
        end
    endtask

    task automatic test_random();
        int cyc; logic [7:0] p; bit gb; bit b; logic [3:0] x, y;
        for (int i = 0; i < 10; i++) begin
            b = 1'($urandom_range(0, 1));
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            issue(b, x, y);
            wait_ack(1'b1, cyc, p, gb);
            ref_last_b = ref_pick_b(!b, b);
            n_checks++;
            if (p !== ref_mul(x, y) || gb !== b || cyc !== LAT)
                $display("FAIL random_%0d: got p=%h b=%b cyc=%0d want %h/%b/%0d", i, p, gb, cyc, ref_mul(x, y), b, LAT);
            else n_pass++;
            n_checks++;
            if ((b ? st_gnt_a : st_gnt_b) !== 0)
                $display("FAIL random_other_gnt_%0d: got %0d cycles want 0", i, b ? st_gnt_a : st_gnt_b);
            else n_pass++;
            settle();
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [7:0] p; bit gb; bit exp_b;
        RST = 1'b1; settle(); RST = 1'b0;
        ref_last_b = 1'b1;
        XA = 4'd3; YA = 4'd5; XB = 4'd6; YB = 4'd2;
        REQ_A = 1'b1; REQ_B = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(1'b0, cyc, p, gb);
            exp_b = ref_pick_b(1'b1, 1'b1);
            ref_last_b = exp_b;
            n_checks++;
            if (gb !== exp_b || p !== (exp_b ? ref_mul(4'd6, 4'd2) : ref_mul(4'd3, 4'd5)) || cyc !== (i == 0 ? LAT : LAT + 1))
                $display("FAIL b2b_%0d: got b=%b p=%h cyc=%0d want %b/%h/%0d", i, gb, p, cyc, exp_b,
                         exp_b ? ref_mul(4'd6, 4'd2) : ref_mul(4'd3, 4'd5), i == 0 ? LAT : LAT + 1);
            else n_pass++;
        end
        REQ_A = 1'b0; REQ_B = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid();
        int cyc; logic [7:0] p; bit gb;
        issue(1'b0, 4'd9, 4'd9);
        repeat (6) settle();
        n_checks++;
        if (BUSY !== 1'b1 || GNT_A !== 1'b1) $display("FAIL midrst_pre: got busy=%b gnt=%b want 1/1", BUSY, GNT_A); else n_pass++;
        RST = 1'b1; REQ_A = 1'b0;
        settle();
        n_checks++;
        if ({BUSY, GNT_A, GNT_B, ACK_A, ACK_B, MUL_LOAD, MUL_RSEL, MUL_CLK, MUL_DIN, P} !== 20'b0)
            $display("FAIL midrst_outputs: got busy=%b gnt=%b%b ack=%b%b mul=%b%b%b din=%h p=%h want all 0",
                     BUSY, GNT_A, GNT_B, ACK_A, ACK_B, MUL_LOAD, MUL_RSEL, MUL_CLK, MUL_DIN, P);
        else n_pass++;
        RST = 1'b0;
        ref_last_b = 1'b1;
        issue(1'b0, 4'd4, 4'd4);
        wait_ack(1'b1, cyc, p, gb);
        ref_last_b = 1'b0;
        n_checks++;
        if (p !== 8'h10 || cyc !== LAT || gb !== 1'b0) $display("FAIL midrst_fresh: got p=%h cyc=%0d want 10/%0d", p, cyc, LAT); else n_pass++;
        settle();
    endtask

    task automatic test_operand_latch();
        int cyc; logic [7:0] p; bit gb;
        issue(1'b0, 4'd5, 4'd5);
        settle();
        n_checks++;
        if (GNT_A !== 1'b1) $display("FAIL latch_gnt: got %b want 1", GNT_A); else n_pass++;
        settle();
        XA = 4'd0; YA = 4'd0;
        wait_ack(1'b1, cyc, p, gb);
        ref_last_b = 1'b0;
        n_checks++;
        if (p !== 8'h19 || cyc + 2 !== LAT) $display("FAIL latch_product: got p=%h cyc=%0d want 19/%0d", p, cyc + 2, LAT); else n_pass++;
        settle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_operand_latch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
